// File: rtl/oled_send_arbiter.sv
// Round-robin, message-atomic sharing of the OLED byte-send port between NUM_REQ text sources.
// Defining OLED_ARB_TIMEOUT_EN adds a SEND watchdog that aborts a stalled message via timeout_err.
module oled_send_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ack,
  output logic [7:0]           o_sendData,
  output logic                 o_sendDataValid,
  input  logic                 i_sendDone,
  output logic                 o_grant_valid,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr,      w_rr_ptr_nxt;
  logic [ID_W-1:0]     r_grant_id,    w_grant_id_nxt;
  logic                r_grant_valid, w_grant_valid_nxt;
  logic [7:0]          r_send_data,   w_send_data_nxt;
  logic                r_send_valid,  w_send_valid_nxt;
  logic [NUM_REQ-1:0]  r_req_ack,     w_req_ack_nxt;
  logic                r_last_q,      w_last_q_nxt;
  logic                r_timeout_err, w_timeout_err_nxt;

  logic                w_sel_valid;
  logic                w_sel_last;
  logic [7:0]          w_sel_data;
  logic [NUM_REQ-1:0]  w_rot;
  logic [ID_W:0]       w_sum;
  logic                w_any_req;
  logic [ID_W-1:0]     w_winner;
  logic                w_timeout;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[8*i +: 8];
      end
    end
  end

  // Rotate so bit 0 is rr_ptr; the first set bit gives the offset from rr_ptr.
  always_comb begin
    w_rot     = NUM_REQ'({i_req_valid, i_req_valid} >> r_rr_ptr);
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_any_req && w_rot[i]) begin
        w_any_req = 1'b1;
        w_sum     = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      end
    end
    if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
      w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    end
    w_winner = w_sum[ID_W-1:0];
  end

`ifdef OLED_ARB_TIMEOUT_EN
  logic [31:0] r_to_cnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_to_cnt <= '0;
    end else if (r_state != S_SEND) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'd1;
    end
  end

  assign w_timeout = (r_state == S_SEND) && (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_send_data   <= 8'h00;
      r_send_valid  <= 1'b0;
      r_req_ack     <= '0;
      r_last_q      <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_send_data   <= w_send_data_nxt;
      r_send_valid  <= w_send_valid_nxt;
      r_req_ack     <= w_req_ack_nxt;
      r_last_q      <= w_last_q_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req && !i_sendDone) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_sel_valid) w_state_nxt = S_SEND;
      S_SEND:  if (i_sendDone || w_timeout) w_state_nxt = S_GAP;
      S_GAP:   if (!i_sendDone) w_state_nxt = r_last_q ? S_IDLE : S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_send_data_nxt   = r_send_data;
    w_send_valid_nxt  = r_send_valid;
    w_req_ack_nxt     = '0;
    w_last_q_nxt      = r_last_q;
    w_timeout_err_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req && !i_sendDone) begin
          w_grant_id_nxt    = w_winner;
          w_grant_valid_nxt = 1'b1;
        end
      end
      S_LOAD: begin
        if (w_sel_valid) begin
          w_send_data_nxt  = w_sel_data;
          w_last_q_nxt     = w_sel_last;
          w_send_valid_nxt = 1'b1;
          for (int i = 0; i < NUM_REQ; i++) begin
            w_req_ack_nxt[i] = (r_grant_id == ID_W'(i));
          end
        end
      end
      S_SEND: begin
        if (i_sendDone) begin
          w_send_valid_nxt = 1'b0;
        end else if (w_timeout) begin
          // Abort: release the grant at GAP as though this byte were the last.
          w_send_valid_nxt  = 1'b0;
          w_last_q_nxt      = 1'b1;
          w_timeout_err_nxt = 1'b1;
        end
      end
      S_GAP: begin
        if (!i_sendDone && r_last_q) begin
          w_grant_valid_nxt = 1'b0;
          w_rr_ptr_nxt      = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_req_ack       = r_req_ack;
  assign o_sendData      = r_send_data;
  assign o_sendDataValid = r_send_valid;
  assign o_grant_valid   = r_grant_valid;
  assign o_grant_id      = r_grant_id;
  assign o_timeout_err   = r_timeout_err;

endmodule

// File: doc/oled_send_arbiter.md
Name: oled_send_arbiter

Overview:
- Shares the single byte-send port of the OLED controller (sendData / sendDataValid / sendDone) between NUM_REQ independent text sources.
- Grants are round-robin and message-atomic: once granted, a requester keeps the port until its byte flagged last has completed.
- Sits between the text/status generators and the OLED controller, replacing per-source ad-hoc send sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_id; must be >= clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1000000, maximum clock cycles to wait for sendDone in SEND (used only with the optional feature).

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
- req_data  in  NUM_REQ*8  byte per requester; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  the presented byte ends the message.
- req_ack  out  NUM_REQ  one-cycle pulse: byte captured; requester advances to its next byte.
- sendData  out  8  byte to the OLED controller.
- sendDataValid  out  1  byte request to the OLED controller.
- sendDone  in  1  OLED controller completion flag.
- grant_valid  out  1  a message is in progress.
- grant_id  out  ID_W  index of the granted requester.
- timeout_err  out  1  one-cycle abort pulse.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, rr_ptr = 0.
  - All outputs are 0: sendData = 8'h00, sendDataValid = 0, req_ack = 0, grant_valid = 0, grant_id = 0, timeout_err = 0.
  - Reset asserted mid-SEND drops sendDataValid immediately; the message is abandoned and no ack is issued.
- All outputs are registered.
- IDLE:
  - Waits until any req_valid = 1 and sendDone = 0.
  - Winner is the first set req_valid scanning upward from rr_ptr, wrapping at NUM_REQ-1 -> 0.
  - Registers grant_id = winner and grant_valid = 1, then goes to LOAD.
- LOAD:
  - If req_valid[grant_id] = 1: sendData <= that requester's slice, last_q <= req_last[grant_id], sendDataValid <= 1, req_ack[grant_id] <= 1 for exactly one cycle, then go to SEND.
  - If req_valid[grant_id] = 0 (mid-message bubble): stay in LOAD with the grant held; other requesters are not served.
- SEND:
  - sendData is held stable and sendDataValid held at 1 until sendDone = 1.
  - On sendDone = 1: sendDataValid <= 0, go to GAP.
- GAP:
  - Waits for sendDone = 0.
  - If last_q = 1: grant_valid <= 0, rr_ptr <= (grant_id+1) mod NUM_REQ, go to IDLE.
  - Otherwise go to LOAD.
- Latency:
  - Request seen in IDLE at cycle t -> sendDataValid and req_ack high at t+2.
  - sendDone low in GAP at cycle u -> next byte valid at u+2.
- Requester side:
  - A requester must hold req_data and req_last stable while req_valid is high until it sees its ack.
  - req_ack is the only acceptance indication.
- Simultaneous events:
  - New requests arriving during a message wait; rr_ptr is not updated until the message ends.
  - A single-byte message (req_last = 1 on the first byte) behaves identically.
- sendDone already high on entry to IDLE: no grant is made until it falls.
- The arbiter never drives sendDataValid while sendDone is high from a previous byte.

Optional Feature:
- Macro: OLED_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to SEND and increments each SEND cycle.
  - On reaching TIMEOUT_CYCLES without sendDone: sendDataValid <= 0, timeout_err pulses for 1 cycle, and the remainder of the message is abandoned.
  - The arbiter then goes to GAP as if last_q = 1: the grant is released and rr_ptr advances.
- Undefined: no counter; timeout_err is tied 0 and SEND waits indefinitely.

Test Plan:
- Requester 0 sends 3 bytes 8'h53, 8'h68, 8'h72 (last on 8'h72); model sendDone 10 cycles after valid -> sendData sequence 53/68/72 and 3 req_ack[0] pulses; grant_valid falls after the third GAP; rr_ptr = 1.
- Requesters 0 and 2 both request 2-byte messages at the same cycle from reset -> requester 0 served fully first, then requester 2; grant_id = 0 then 2; no interleaving of bytes.
- Requester 1 drops req_valid for 20 cycles between byte 1 and byte 2 while requester 3 is valid -> arbiter stays in LOAD with grant_id = 1; requester 3 starts only after requester 1's last byte.
- sendDone stuck high for 15 cycles after reset with requester 0 valid -> sendDataValid stays 0 until 2 cycles after sendDone falls.
- Assert reset 3 cycles into SEND -> sendDataValid, grant_valid and req_ack all 0 in the same cycle; after release, the arbiter re-arbitrates from rr_ptr = 0.
- With OLED_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES = 50, sendDone never asserted -> timeout_err pulses at SEND cycle 50, sendDataValid drops, and the next requester is granted.
